// File: rtl/resp_misr.sv
// =============================================================================
// Module   : resp_misr
// Brief    : Response-side MISR compactor: folds N accepted Y samples into a
//            W-bit signature and compares it against a golden value.
//            Optional idle timeout: define RESP_MISR_TIMEOUT_EN.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module resp_misr #(
    parameter int            W    = 96,
    parameter int            N    = 99,
    parameter int            CW   = 8,
    parameter logic [W-1:0]  POLY = W'('h41),
    parameter logic [W-1:0]  INIT = '0
`ifdef RESP_MISR_TIMEOUT_EN
    ,
    parameter int            TO   = 255
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          en,
    input  logic [W-1:0]  Y,
    input  logic [W-1:0]  golden,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [W-1:0]  sig,
    output logic [CW-1:0] count
`ifdef RESP_MISR_TIMEOUT_EN
    ,
    output logic          timeout
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] c_last = CW'(N - 1);

    state_t        r_state, w_state_nxt;
    logic [W-1:0]  r_sig,   w_sig_nxt;
    logic [CW-1:0] r_count, w_count_nxt;
    logic          r_pass,  w_pass_nxt;
    logic [W-1:0]  w_misr;

`ifdef RESP_MISR_TIMEOUT_EN
    localparam int              c_iw      = $clog2(TO + 1);
    localparam logic [c_iw-1:0] c_to_last = c_iw'(TO - 1);

    logic [c_iw-1:0] r_idle,    w_idle_nxt;
    logic            r_timeout, w_timeout_nxt;
`endif

    // Rotate first (MSB wraps into bit 0), then fold in the sample and taps.
    assign w_misr = {r_sig[W-2:0], r_sig[W-1]} ^ Y ^ (r_sig[W-1] ? POLY : '0);

    always_comb begin
        w_state_nxt = r_state;
        w_sig_nxt   = r_sig;
        w_count_nxt = r_count;
        w_pass_nxt  = r_pass;
`ifdef RESP_MISR_TIMEOUT_EN
        w_idle_nxt    = r_idle;
        w_timeout_nxt = r_timeout;
`endif
        case (r_state)
            S_IDLE, S_DONE: begin
                // A start cycle never consumes the en sample that arrives with it.
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_sig_nxt   = INIT;
                    w_count_nxt = '0;
                    w_pass_nxt  = 1'b0;
`ifdef RESP_MISR_TIMEOUT_EN
                    w_idle_nxt    = '0;
                    w_timeout_nxt = 1'b0;
`endif
                end
            end
            S_RUN: begin
                if (en) begin
                    w_sig_nxt   = w_misr;
                    w_count_nxt = r_count + 1'b1;
`ifdef RESP_MISR_TIMEOUT_EN
                    w_idle_nxt  = '0;
`endif
                    if (r_count == c_last) begin
                        w_state_nxt = S_DONE;
                        w_pass_nxt  = (w_misr == golden);
                    end
                end
`ifdef RESP_MISR_TIMEOUT_EN
                else begin
                    w_idle_nxt = r_idle + 1'b1;
                    if (r_idle == c_to_last) begin
                        w_state_nxt   = S_DONE;
                        w_pass_nxt    = 1'b0;
                        w_timeout_nxt = 1'b1;
                    end
                end
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_sig   <= INIT;
            r_count <= '0;
            r_pass  <= 1'b0;
`ifdef RESP_MISR_TIMEOUT_EN
            r_idle    <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_sig   <= w_sig_nxt;
            r_count <= w_count_nxt;
            r_pass  <= w_pass_nxt;
`ifdef RESP_MISR_TIMEOUT_EN
            r_idle    <= w_idle_nxt;
            r_timeout <= w_timeout_nxt;
`endif
        end
    end

    assign busy  = (r_state == S_RUN);
    assign done  = (r_state == S_DONE);
    assign pass  = r_pass;
    assign sig   = r_sig;
    assign count = r_count;
`ifdef RESP_MISR_TIMEOUT_EN
    assign timeout = r_timeout;
`endif

endmodule

`default_nettype wire

// File: tb/tb_resp_misr.sv
// =============================================================================
// Module   : tb_resp_misr
// Brief    : Drives several resp_misr instances (N=1,2,4 and, with
//            RESP_MISR_TIMEOUT_EN, an N=4/TO=4 one) from shared stimulus and
//            checks every cycle against a per-instance reference model.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_resp_misr;

    localparam int c_w   = 96;
    localparam int c_to  = 4;
`ifdef RESP_MISR_TIMEOUT_EN
    localparam int c_ni  = 4;
`else
    localparam int c_ni  = 3;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            en;
    logic [c_w-1:0]  Y;
    logic [c_w-1:0]  golden;

    logic            busy_w [c_ni];
    logic            done_w [c_ni];
    logic            pass_w [c_ni];
    logic [c_w-1:0]  sig_w  [c_ni];
    logic [7:0]      cnt_w  [c_ni];
`ifdef RESP_MISR_TIMEOUT_EN
    logic            to_w   [c_ni];
`endif

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    function automatic int n_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 4;
    endfunction

    generate
        for (genvar k = 0; k < c_ni; k++) begin : g_dut
            resp_misr #(
                .W (c_w),
                .N (n_of(k)),
                .CW(8)
`ifdef RESP_MISR_TIMEOUT_EN
                ,
                .TO(c_to)
`endif
            ) u_dut (
                .clk    (clk),
                .rst    (rst),
                .start  (start),
                .en     (en),
                .Y      (Y),
                .golden (golden),
                .busy   (busy_w[k]),
                .done   (done_w[k]),
                .pass   (pass_w[k]),
                .sig    (sig_w[k]),
                .count  (cnt_w[k])
`ifdef RESP_MISR_TIMEOUT_EN
                ,
                .timeout(to_w[k])
`endif
            );
        end
    endgenerate

    // Reference: rotate-left by one, XOR taps if the old MSB was set, XOR sample.
    function automatic logic [c_w-1:0] misr(input logic [c_w-1:0] s, input logic [c_w-1:0] y);
        logic [c_w-1:0] rot;
        rot = (s << 1) | (s >> (c_w - 1));
        return rot ^ y ^ (s[c_w-1] ? c_w'('h41) : '0);
    endfunction

    // Model state: 0 idle, 1 run, 2 done.
    int             m_st   [4];
    logic [c_w-1:0] m_sig  [4];
    int             m_cnt  [4];
    bit             m_pass [4];
    int             m_idle [4];
    bit             m_to   [4];

    always @(posedge clk) begin
        for (int k = 0; k < c_ni; k++) begin
            if (!rst) begin
                m_st[k] <= 0; m_sig[k] <= '0; m_cnt[k] <= 0;
                m_pass[k] <= 1'b0; m_idle[k] <= 0; m_to[k] <= 1'b0;
            end else if (m_st[k] != 1) begin
                if (start) begin
                    m_st[k] <= 1; m_sig[k] <= '0; m_cnt[k] <= 0;
                    m_pass[k] <= 1'b0; m_idle[k] <= 0; m_to[k] <= 1'b0;
                end
            end else if (en) begin
                m_sig[k]  <= misr(m_sig[k], Y);
                m_cnt[k]  <= m_cnt[k] + 1;
                m_idle[k] <= 0;
                if (m_cnt[k] + 1 == n_of(k)) begin
                    m_st[k]   <= 2;
                    m_pass[k] <= (misr(m_sig[k], Y) == golden);
                end
            end else if (k == 3) begin
                m_idle[k] <= m_idle[k] + 1;
                if (m_idle[k] + 1 == c_to) begin
                    m_st[k] <= 2; m_pass[k] <= 1'b0; m_to[k] <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [c_w-1:0] act, input logic [c_w-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < c_ni; k++) begin
                chk($sformatf("busy[%0d]", k), c_w'(busy_w[k]), c_w'(m_st[k] == 1));
                chk($sformatf("done[%0d]", k), c_w'(done_w[k]), c_w'(m_st[k] == 2));
                chk($sformatf("pass[%0d]", k), c_w'(pass_w[k]), c_w'(m_pass[k]));
                chk($sformatf("sig[%0d]", k), sig_w[k], m_sig[k]);
                chk($sformatf("count[%0d]", k), c_w'(cnt_w[k]), c_w'(m_cnt[k]));
`ifdef RESP_MISR_TIMEOUT_EN
                chk($sformatf("timeout[%0d]", k), c_w'(to_w[k]), c_w'(m_to[k]));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; en = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; en = 1'b0; Y = '0; golden = '0;
        tick();
        tick();
        rst = 1'b1;
        chk_on = 1'b1;
        chk("rst_sig", sig_w[0], '0);
        chk("rst_busy", c_w'(busy_w[0]), '0);

        // 1: N=1, a single sample ends the run
        start = 1'b1; tick(); start = 1'b0;
        chk("t1_busy", c_w'(busy_w[0]), 1);
        en = 1'b1; Y = 1; golden = 1; tick(); en = 1'b0;
        chk("t1_done", c_w'(done_w[0]), 1);
        chk("t1_sig", sig_w[0], 1);
        chk("t1_pass", c_w'(pass_w[0]), 1);
        chk("t1_count", c_w'(cnt_w[0]), 1);

        // 2: N=2, two ones -> 3; pass with golden 3, fail with golden 2
        do_reset();
        for (int g = 3; g >= 2; g--) begin
            start = 1'b1; tick(); start = 1'b0;
            golden = c_w'(g);
            en = 1'b1; Y = 1; tick(); tick(); en = 1'b0;
            chk("t2_sig", sig_w[1], 3);
            chk("t2_count", c_w'(cnt_w[1]), 2);
            chk("t2_done", c_w'(done_w[1]), 1);
            chk("t2_pass", c_w'(pass_w[1]), (g == 3) ? 1 : 0);
            tick();
        end

        // 3: MSB wrap engages the 0x41 taps
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        golden = c_w'('h40);
        en = 1'b1; Y = '0; Y[c_w-1] = 1'b1; tick();
        chk("t3_sig1", sig_w[1], {1'b1, {(c_w-1){1'b0}}});
        Y = '0; tick(); en = 1'b0;
        chk("t3_sig2", sig_w[1], c_w'('h40));
        chk("t3_pass", c_w'(pass_w[1]), 1);

        // 4: start+en in IDLE excluded; start ignored in RUN; gapped en
        do_reset();
        golden = c_w'('hF); Y = 1;
        start = 1'b1; en = 1'b1; tick(); start = 1'b0;
        chk("t4_cnt0", c_w'(cnt_w[2]), 0);
        for (int c = 0; c < 7; c++) begin
            en = (c % 2 == 0);
            start = (c == 3);
            tick();
            if (c == 5) chk("t4_notyet", c_w'(done_w[2]), 0);
        end
        en = 1'b0; start = 1'b0;
        chk("t4_done", c_w'(done_w[2]), 1);
        chk("t4_count", c_w'(cnt_w[2]), 4);
        chk("t4_sig", sig_w[2], c_w'('hF));
        chk("t4_pass", c_w'(pass_w[2]), 1);
        en = 1'b1; tick(); en = 1'b0;
        chk("t4_frozen", sig_w[2], c_w'('hF));

        // 5: reset mid-run, then a clean run
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        en = 1'b1; tick(); tick(); en = 1'b0;
        do_reset();
        chk("t5_busy", c_w'(busy_w[2]), 0);
        chk("t5_done", c_w'(done_w[2]), 0);
        chk("t5_sig", sig_w[2], 0);
        chk("t5_count", c_w'(cnt_w[2]), 0);
        start = 1'b1; tick(); start = 1'b0;
        en = 1'b1; for (int c = 0; c < 4; c++) tick(); en = 1'b0;
        chk("t5_sig_run", sig_w[2], c_w'('hF));
        chk("t5_pass_run", c_w'(pass_w[2]), 1);

`ifdef RESP_MISR_TIMEOUT_EN
        // 6: four idle cycles in RUN force a timeout
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        begin
            int n;
            n = 0;
            while (!done_w[3] && n < 10) begin tick(); n++; end
            chk("t6_latency", c_w'(n), c_to);
        end
        chk("t6_timeout", c_w'(to_w[3]), 1);
        chk("t6_pass", c_w'(pass_w[3]), 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("t6_cleared", c_w'(to_w[3]), 0);
        chk("t6_busy", c_w'(busy_w[3]), 1);
`endif

        tick();
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
